// File: rtl/vga_draw_scheduler.sv
// Round-robin arbiter sharing the VGA write port among four draw requesters.
// Optional grant watchdog: define VGA_DRAW_SCHED_WATCHDOG_EN to build it.
module vga_draw_scheduler #(
    parameter int N_REQ      = 4,
    parameter int WDT_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [N_REQ-1:0]     wren_in,
    input  logic [15*N_REQ-1:0]  coord_in,
    input  logic [9*N_REQ-1:0]   colour_in,
    input  logic                 frame_start,
    output logic [N_REQ-1:0]     grant,
    output logic [14:0]          coord,
    output logic [8:0]           colour,
    output logic                 vga_wren,
    output logic                 busy,
    output logic                 timeout_flag,
    output logic [1:0]           timeout_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gid_q, gid_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             fpend_q, fpend_d;

    logic [1:0]       base;
    logic             pick_vld;
    logic [1:0]       pick_id;
    logic             done_hit;
    logic             wdt_fire;

    assign done_hit = done[gid_q];

    // First requester at or above the pointer, wrapping; frame start rescans from 0
    always_comb begin
        base     = frame_start ? 2'd0 : ptr_q;
        pick_vld = 1'b0;
        pick_id  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[base + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_id  = base + 2'(k);
            end
        end
    end

    // Next-state logic: grant, hold until done/watchdog, one dead cycle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        grant_d = grant_q;
        fpend_d = fpend_q;
        unique case (state_q)
            IDLE: begin
                if (frame_start) ptr_d = 2'd0;
                if (pick_vld) begin
                    state_d          = ACTIVE;
                    gid_d            = pick_id;
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                end
            end
            ACTIVE: begin
                if (frame_start) fpend_d = 1'b1;
                if (done_hit || wdt_fire) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    fpend_d = 1'b0;
                    ptr_d   = (fpend_q || frame_start) ? 2'd0 : gid_q + 2'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                if (frame_start) ptr_d = 2'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gid_q   <= 2'd0;
            grant_q <= '0;
            fpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            grant_q <= grant_d;
            fpend_q <= fpend_d;
        end
    end

`ifdef VGA_DRAW_SCHED_WATCHDOG_EN
    localparam logic [15:0] WDT_LIM = 16'(WDT_CYCLES - 1);

    logic [15:0] wdt_cnt_q, wdt_cnt_d;
    logic        to_flag_q, to_flag_d;
    logic [1:0]  to_id_q, to_id_d;

    assign wdt_fire  = (state_q == ACTIVE) && (wdt_cnt_q == WDT_LIM);
    assign wdt_cnt_d = (state_q == ACTIVE) ? wdt_cnt_q + 16'd1 : 16'd0;

    // A coincident done wins: it is a normal release, not a timeout
    always_comb begin
        to_flag_d = to_flag_q;
        to_id_d   = to_id_q;
        if (wdt_fire && !done_hit) begin
            to_flag_d = 1'b1;
            to_id_d   = gid_q;
        end
    end

    // Watchdog counter and sticky timeout record
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdt_cnt_q <= 16'd0;
            to_flag_q <= 1'b0;
            to_id_q   <= 2'd0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            to_flag_q <= to_flag_d;
            to_id_q   <= to_id_d;
        end
    end

    assign timeout_flag = to_flag_q;
    assign timeout_id   = to_id_q;
`else
    assign wdt_fire     = 1'b0;
    assign timeout_flag = 1'b0;
    assign timeout_id   = 2'd0;
`endif

    // Zero-latency port mux, forced quiet outside ACTIVE
    always_comb begin
        coord    = 15'd0;
        colour   = 9'd0;
        vga_wren = 1'b0;
        if (state_q == ACTIVE) begin
            coord    = coord_in[15*gid_q +: 15];
            colour   = colour_in[9*gid_q +: 9];
            vga_wren = wren_in[gid_q];
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ACTIVE);

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Directed bench for vga_draw_scheduler with a grant-order scoreboard.
// Watchdog checks follow VGA_DRAW_SCHED_WATCHDOG_EN.
module tb_vga_draw_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [3:0]  wren_in;
    logic [59:0] coord_in;
    logic [35:0] colour_in;
    logic        frame_start;
    logic [3:0]  grant;
    logic [14:0] coord;
    logic [8:0]  colour;
    logic        vga_wren;
    logic        busy;
    logic        timeout_flag;
    logic [1:0]  timeout_id;

    int vectors = 0;
    int errs    = 0;
    logic [3:0] exp_q[$];

    vga_draw_scheduler #(
        .N_REQ      (4),
        .WDT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req          (req),
        .done         (done),
        .wren_in      (wren_in),
        .coord_in     (coord_in),
        .colour_in    (colour_in),
        .frame_start  (frame_start),
        .grant        (grant),
        .coord        (coord),
        .colour       (colour),
        .vga_wren     (vga_wren),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .timeout_id   (timeout_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag, output int n);
        logic [3:0] e;
        n = 0;
        while (grant == 4'd0 && n < 50) begin
            step();
            n++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hF;
        chk(tag, int'(grant), int'(e));
    endtask

    task automatic pulse_done(input logic [3:0] d);
        done = d;
        step();
        done = 4'd0;
    endtask

    initial begin
        int n;
        int id;
        resetn      = 1'b0;
        req         = 4'd0;
        done        = 4'd0;
        wren_in     = 4'd0;
        coord_in    = '0;
        colour_in   = '0;
        frame_start = 1'b0;
        repeat (3) step();
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_coord", int'(coord), 0);
        chk("rst_wren", int'(vga_wren), 0);
        chk("rst_tflag", int'(timeout_flag), 0);
        resetn = 1'b1;
        step();

        // single requester: tower
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_grant("single_grant", n);
        chk("single_lat", n, 1);
        chk("single_busy", int'(busy), 1);
        repeat (5) step();
        chk("single_hold", int'(grant), 4'b0010);
        pulse_done(4'b0010);
        chk("single_rel", int'(grant), 0);
        chk("single_rel_busy", int'(busy), 0);
        // ptr = 2: bg and tower both ask, scan 2,3,0 picks bg
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        wait_grant("ptr2_pick", n);
        chk("ptr2_gap", n, 2);
        pulse_done(4'b0001);

        // mux isolation: tower granted, enemy noise
        coord_in[15 +: 15]  = 15'h1234;
        colour_in[9 +: 9]   = 9'h1A5;
        coord_in[30 +: 15]  = 15'h7FFF;
        colour_in[18 +: 9]  = 9'h1FF;
        wren_in = 4'b0100;
        req     = 4'b0110;
        exp_q.push_back(4'b0010);
        wait_grant("mux_grant", n);
        chk("mux_coord", int'(coord), 15'h1234);
        chk("mux_colour", int'(colour), 9'h1A5);
        chk("mux_wren_lo", int'(vga_wren), 0);
        wren_in = 4'b0110;
        #1;
        chk("mux_wren_hi", int'(vga_wren), 1);
        pulse_done(4'b0100);
        chk("mux_foreign_done", int'(grant), 4'b0010);
        pulse_done(4'b0010);
        chk("mux_idle_coord", int'(coord), 0);
        chk("mux_idle_wren", int'(vga_wren), 0);
        wren_in = 4'd0;
        req     = 4'd0;
        step();

        // frame start in IDLE resets ptr, then full rotation
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 4'b1111;
        id  = 0;
        for (int g = 0; g < 5; g++) begin
            exp_q.push_back(4'b0001 << id);
            wait_grant("rr_order", n);
            if (g != 0) chk("rr_gap", n, 2);
            repeat (9) step();
            pulse_done(grant);
            id = (id + 1) % 4;
        end
        req = 4'd0;
        step();
        step();

        // frame start mid-grant: tower done, next is bg not enemy
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_grant("fs_tower", n);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 4'b1111;
        step();
        pulse_done(4'b0010);
        exp_q.push_back(4'b0001);
        wait_grant("fs_restart", n);
        // frame start coincident with done
        frame_start = 1'b1;
        pulse_done(4'b0001);
        frame_start = 1'b0;
        exp_q.push_back(4'b0001);
        wait_grant("fs_coinc", n);
        req = 4'd0;
        pulse_done(4'b0001);
        step();

        // enemy held without done
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant("wdt_grant", n);
        req = 4'd0;
        repeat (15) step();
        chk("wdt_hold15", int'(grant), 4'b0100);
        step();
`ifdef VGA_DRAW_SCHED_WATCHDOG_EN
        chk("wdt_drop", int'(grant), 0);
        chk("wdt_flag", int'(timeout_flag), 1);
        chk("wdt_id", int'(timeout_id), 2);
        step();
        step();
`else
        chk("nowdt_held", int'(grant), 4'b0100);
        repeat (30) step();
        chk("nowdt_held_long", int'(grant), 4'b0100);
        chk("nowdt_flag", int'(timeout_flag), 0);
        pulse_done(4'b0100);
        step();
`endif

        // reset mid-grant
        wren_in = 4'b0100;
        req     = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant("rstmid_grant", n);
        chk("rstmid_wren", int'(vga_wren), 1);
        resetn = 1'b0;
        #1;
        chk("rstmid_grant0", int'(grant), 0);
        chk("rstmid_wren0", int'(vga_wren), 0);
        chk("rstmid_busy0", int'(busy), 0);
        chk("rstmid_tflag", int'(timeout_flag), 0);
        step();
        resetn = 1'b1;
        req    = 4'b1000;
        exp_q.push_back(4'b1000);
        wait_grant("rstmid_hud", n);
        chk("rstmid_lat", n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
